hazard_stall_controller: RTL and testbench

- Pipeline sequencer for the 5-stage MIPS core.
- Decides each cycle whether the PC, IF/ID and ID/EX registers advance, hold or are flushed.
- Covers load-use hazards, taken branches and jumps, multi-cycle mult/div occupancy of EX, and external memory-not-ready stalls.
- Works alongside the forwarding unit: it handles the hazards forwarding cannot resolve and owns every pipeline-register enable/flush.

---
 rtl/hazard_stall_controller.sv | 138 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage MIPS core: PC / IF/ID / ID/EX enables and flushes.
// Optional statistics counters are enabled by defining STALL_STATS_EN.
module hazard_stall_controller #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IF_ID_Rs,
    input  logic [4:0] IF_ID_Rt,
    input  logic [4:0] ID_EX_Rt,
    input  logic       ID_EX_MemRead,
    input  logic       MD_Start,
    input  logic       Branch_Taken,
    input  logic       Jump,
    input  logic       Ext_Stall,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       ID_EX_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       Pipe_Freeze,
    output logic       MD_Busy
`ifdef STALL_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] Stall_Cycles,
    output logic [CNT_WIDTH-1:0] Flush_Events
`endif
);

    localparam int unsigned MD_CNT_W = 4;

    if (MD_LATENCY < 1 || MD_LATENCY > 15) begin : g_bad_md_latency
        $error("hazard_stall_controller: MD_LATENCY must be in 1..15");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("hazard_stall_controller: CNT_WIDTH must be at least 1");
    end

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    state_e              state;
    state_e              state_nxt;
    logic [MD_CNT_W-1:0] md_cnt;
    logic [MD_CNT_W-1:0] md_cnt_nxt;
    logic                load_use;

    // Load in EX writing a register the ID instruction reads; $zero never hazards.
    assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Prioritised event decode: Ext_Stall, MD_BUSY, branch, mult/div start, load-use, jump.
    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        ID_EX_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        Pipe_Freeze = 1'b0;
        MD_Busy     = 1'b0;

        if (!reset) begin
            state_nxt   = RUN;
            md_cnt_nxt  = '0;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (Ext_Stall) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            Pipe_Freeze = 1'b1;
            MD_Busy     = (state == MD_BUSY);
        end else if (state == MD_BUSY) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            MD_Busy     = 1'b1;
            if (md_cnt == '0) begin
                state_nxt = RUN;
            end else begin
                md_cnt_nxt = md_cnt - MD_CNT_W'(1);
            end
        end else if (Branch_Taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (MD_Start && (MD_LATENCY > 1)) begin
            // The start cycle is the first of MD_LATENCY hold cycles.
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            MD_Busy     = 1'b1;
            state_nxt   = MD_BUSY;
            md_cnt_nxt  = MD_CNT_W'(MD_LATENCY - 2);
        end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (Jump) begin
            IF_ID_Flush = 1'b1;
        end
    end

`ifdef STALL_STATS_EN
    // Saturating stall/flush statistics, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Stall_Cycles <= '0;
            Flush_Events <= '0;
        end else begin
            if (!PCWrite && (Stall_Cycles != '1)) begin
                Stall_Cycles <= Stall_Cycles + CNT_WIDTH'(1);
            end
            if ((IF_ID_Flush || ID_EX_Flush) && (Flush_Events != '1)) begin
                Flush_Events <= Flush_Events + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller (MD_LATENCY 4 and 1 instances).
// Output vectors are {PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze, MD_Busy}.
module tb_hazard_stall_controller;

    localparam logic [6:0] DEF = 7'b1110000;
    localparam logic [6:0] RST = 7'b0001100;
    localparam logic [6:0] MDH = 7'b0000001;
    localparam logic [6:0] FRZ = 7'b0000010;
    localparam logic [6:0] FMD = 7'b0000011;
    localparam logic [6:0] BR  = 7'b1111100;
    localparam logic [6:0] LU  = 7'b0010100;
    localparam logic [6:0] JMP = 7'b1111000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] if_id_rs = '0;
    logic [4:0] if_id_rt = '0;
    logic [4:0] id_ex_rt = '0;
    logic       id_ex_memread = 1'b0;
    logic       md_start = 1'b0;
    logic       branch_taken = 1'b0;
    logic       jump = 1'b0;
    logic       ext_stall = 1'b0;

    logic pcw4, ifw4, idw4, iff4, idf4, frz4, busy4;
    logic pcw1, ifw1, idw1, iff1, idf1, frz1, busy1;
    logic [6:0] o4, o1;

    int asserts  = 0;
    int failures = 0;

    assign o4 = {pcw4, ifw4, idw4, iff4, idf4, frz4, busy4};
    assign o1 = {pcw1, ifw1, idw1, iff1, idf1, frz1, busy1};

`ifdef STALL_STATS_EN
    logic [15:0] sc4, fe4, sc1, fe1;
`endif

    always #5 clk = ~clk;

    hazard_stall_controller #(.MD_LATENCY(4)) u_lat4 (
        .clk(clk), .reset(reset),
        .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt), .ID_EX_Rt(id_ex_rt),
        .ID_EX_MemRead(id_ex_memread), .MD_Start(md_start),
        .Branch_Taken(branch_taken), .Jump(jump), .Ext_Stall(ext_stall),
        .PCWrite(pcw4), .IF_ID_Write(ifw4), .ID_EX_Write(idw4),
        .IF_ID_Flush(iff4), .ID_EX_Flush(idf4), .Pipe_Freeze(frz4), .MD_Busy(busy4)
`ifdef STALL_STATS_EN
        , .Stall_Cycles(sc4), .Flush_Events(fe4)
`endif
    );

    hazard_stall_controller #(.MD_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt), .ID_EX_Rt(id_ex_rt),
        .ID_EX_MemRead(id_ex_memread), .MD_Start(md_start),
        .Branch_Taken(branch_taken), .Jump(jump), .Ext_Stall(ext_stall),
        .PCWrite(pcw1), .IF_ID_Write(ifw1), .ID_EX_Write(idw1),
        .IF_ID_Flush(iff1), .ID_EX_Flush(idf1), .Pipe_Freeze(frz1), .MD_Busy(busy1)
`ifdef STALL_STATS_EN
        , .Stall_Cycles(sc1), .Flush_Events(fe1)
`endif
    );

    // Advance one cycle, apply new inputs just after the edge, let outputs settle.
    task automatic drive(input logic rst_v, input logic mr, input logic [4:0] exrt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic md,
                         input logic br, input logic j, input logic ext);
        @(posedge clk);
        #1;
        reset = rst_v; id_ex_memread = mr; id_ex_rt = exrt; if_id_rs = rs; if_id_rt = rt;
        md_start = md; branch_taken = br; jump = j; ext_stall = ext;
        #2;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== RST) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", o4, RST); end
        drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        asserts++; if (o4 !== RST) begin failures++; $display("FAIL reset_forced_busy_inputs got=%b exp=%b", o4, RST); end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL reset_release_default got=%b exp=%b", o4, DEF); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== LU) begin failures++; $display("FAIL lu_rs_match got=%b exp=%b", o4, LU); end
        drive(1'b1, 1'b0, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL lu_single_bubble got=%b exp=%b", o4, DEF); end
        drive(1'b1, 1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== LU) begin failures++; $display("FAIL lu_rt_match got=%b exp=%b", o4, LU); end
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL lu_zero_reg got=%b exp=%b", o4, DEF); end
        drive(1'b1, 1'b1, 5'd8, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL lu_no_match got=%b exp=%b", o4, DEF); end
    endtask

    task automatic test_mult_div();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== MDH) begin failures++; $display("FAIL md_start_cycle got=%b exp=%b", o4, MDH); end
        asserts++; if (o1 !== DEF) begin failures++; $display("FAIL md_lat1_no_stall got=%b exp=%b", o1, DEF); end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== MDH) begin failures++; $display("FAIL md_busy_c2 got=%b exp=%b", o4, MDH); end
        asserts++; if (o1 !== DEF) begin failures++; $display("FAIL md_lat1_after got=%b exp=%b", o1, DEF); end
        // Branch, jump and load-use are ignored while mult/div holds EX.
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        asserts++; if (o4 !== MDH) begin failures++; $display("FAIL md_busy_ignores_branch got=%b exp=%b", o4, MDH); end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== MDH) begin failures++; $display("FAIL md_busy_c4 got=%b exp=%b", o4, MDH); end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL md_done_default got=%b exp=%b", o4, DEF); end
    endtask

    task automatic test_ext_stall();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        asserts++; if (o4 !== FRZ) begin failures++; $display("FAIL ext_stall_run got=%b exp=%b", o4, FRZ); end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== MDH) begin failures++; $display("FAIL ext_md_c1 got=%b exp=%b", o4, MDH); end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== MDH) begin failures++; $display("FAIL ext_md_c2 got=%b exp=%b", o4, MDH); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            asserts++; if (o4 !== FMD) begin failures++; $display("FAIL ext_md_freeze%0d got=%b exp=%b", i, o4, FMD); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            asserts++; if (o4 !== MDH) begin failures++; $display("FAIL ext_md_resume%0d got=%b exp=%b", i, o4, MDH); end
        end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL ext_md_done got=%b exp=%b", o4, DEF); end
    endtask

    task automatic test_branch_priority();
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        asserts++; if (o4 !== BR) begin failures++; $display("FAIL branch_over_lu_jump got=%b exp=%b", o4, BR); end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        asserts++; if (o4 !== BR) begin failures++; $display("FAIL branch_over_md_start got=%b exp=%b", o4, BR); end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL branch_no_md_entry got=%b exp=%b", o4, DEF); end
    endtask

    task automatic test_jump_load_use();
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        asserts++; if (o4 !== LU) begin failures++; $display("FAIL jump_with_lu got=%b exp=%b", o4, LU); end
        drive(1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        asserts++; if (o4 !== JMP) begin failures++; $display("FAIL jump_after_lu got=%b exp=%b", o4, JMP); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== MDH) begin failures++; $display("FAIL b2b_second_start got=%b exp=%b", o4, MDH); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            asserts++; if (o4 !== MDH) begin failures++; $display("FAIL b2b_busy%0d got=%b exp=%b", i, o4, MDH); end
        end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL b2b_done got=%b exp=%b", o4, DEF); end
    endtask

    task automatic test_reset_mid_md();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== RST) begin failures++; $display("FAIL rst_mid_md_c2 got=%b exp=%b", o4, RST); end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== RST) begin failures++; $display("FAIL rst_mid_md_held got=%b exp=%b", o4, RST); end
`ifdef STALL_STATS_EN
        asserts++; if (sc4 !== 16'd0) begin failures++; $display("FAIL rst_stall_cycles got=%0d exp=0", sc4); end
        asserts++; if (fe4 !== 16'd0) begin failures++; $display("FAIL rst_flush_events got=%0d exp=0", fe4); end
`endif
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL rst_mid_md_release got=%b exp=%b", o4, DEF); end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        asserts++; if (o4 !== DEF) begin failures++; $display("FAIL rst_mid_md_abandoned got=%b exp=%b", o4, DEF); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mult_div();
        test_ext_stall();
        test_branch_priority();
        test_jump_load_use();
        test_back_to_back();
        test_reset_mid_md();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
